// File: rtl/pc_flow_ctrl_pkg.sv
// Shared types and defaults for the fetch-PC sequencer (pc_flow_ctrl).
package pc_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      BRANCH = 2'd1,
      JUMP   = 2'd2
   } redirect_cause_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] PC_STEP_DEF  = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_redirect_prio.sv
// Combinational priority resolver: picks the redirect cause/target and the
// pipeline strobes for the current sequencer state.
module pc_redirect_prio
   import pc_flow_ctrl_pkg::*;
(
   input  pc_state_e       state,
   input  logic            fetch_done,
   input  logic            load_use,
   input  logic            mdu_busy,
   input  logic            j_en,
   input  logic [31:0]     j_pc,
   input  logic            b_en,
   input  logic [31:0]     b_pc,
   input  logic            halt_req,
   output redirect_cause_e cause,
   output logic [31:0]     target,
   output logic            halt_go,
   output logic            if_id_flush,
   output logic            id_ex_bubble,
   output logic            if_id_hold
);

   // Resolve event priority; older instructions win over younger ones.
   always_comb begin
      cause        = NONE;
      target       = 32'd0;
      halt_go      = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_hold   = 1'b0;
      case (state)
         RUN: begin
            if (mdu_busy) begin
               if_id_hold = 1'b1;
            end else if (b_en) begin
               cause        = BRANCH;
               target       = align_pc(b_pc);
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (load_use) begin
               if_id_hold   = 1'b1;
               id_ex_bubble = 1'b1;
            end else if (halt_req) begin
               halt_go     = 1'b1;
               if_id_flush = 1'b1;
            end else if (j_en) begin
               cause       = JUMP;
               target      = align_pc(j_pc);
               if_id_flush = 1'b1;
            end else begin
               cause = NONE;
            end
         end
         PEND: begin
            // ID-stage work is wrong-path here; only a newer branch matters.
            if (b_en && !mdu_busy) begin
               cause        = BRANCH;
               target       = align_pc(b_pc);
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
            end else begin
               cause = NONE;
            end
            if (fetch_done) begin
               if_id_flush = 1'b1;
            end else begin
               if_id_hold = mdu_busy;
            end
         end
         HALT:    cause = NONE;
         default: cause = NONE;
      endcase
   end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Fetch-PC sequencer: PC register, RUN/PEND/HALT FSM and pipeline strobes.
// Optional perf counters are built when PCFLOW_PERF_EN is defined.
module pc_flow_ctrl
   import pc_flow_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ready,
   input  logic        load_use,
   input  logic        mdu_busy,
   input  logic        j_en,
   input  logic [31:0] j_pc,
   input  logic        b_en,
   input  logic [31:0] b_pc,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        if_id_hold,
   output logic        halted
`ifdef PCFLOW_PERF_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   pc_state_e       state_r, state_nxt_s;
   redirect_cause_e cause_s;
   logic [31:0]     pc_r, pc_nxt_s, pend_pc_r, pend_nxt_s, target_s;
   logic            pc_valid_r, halted_r, fetch_done_s, halt_go_s;
   logic            flush_s, bubble_s, hold_s;

   // A fetch only completes when a request was actually outstanding.
   assign fetch_done_s = imem_ready & pc_valid_r;

   pc_redirect_prio u_prio (
      .state        (state_r),
      .fetch_done   (fetch_done_s),
      .load_use     (load_use),
      .mdu_busy     (mdu_busy),
      .j_en         (j_en),
      .j_pc         (j_pc),
      .b_en         (b_en),
      .b_pc         (b_pc),
      .halt_req     (halt_req),
      .cause        (cause_s),
      .target       (target_s),
      .halt_go      (halt_go_s),
      .if_id_flush  (flush_s),
      .id_ex_bubble (bubble_s),
      .if_id_hold   (hold_s)
   );

   // Next-state, next-PC and parked-target logic.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      pend_nxt_s  = pend_pc_r;
      case (state_r)
         RUN: begin
            if (halt_go_s) begin
               state_nxt_s = HALT;
            end else if (cause_s != NONE) begin
               if (fetch_done_s) begin
                  pc_nxt_s = target_s;
               end else begin
                  pend_nxt_s  = target_s;
                  state_nxt_s = PEND;
               end
            end else if (fetch_done_s && !hold_s) begin
               pc_nxt_s = align_pc(pc_r + PC_STEP);
            end else begin
               pc_nxt_s = pc_r;
            end
         end
         PEND: begin
            if (cause_s == BRANCH) begin
               pend_nxt_s = target_s;
            end else begin
               pend_nxt_s = pend_pc_r;
            end
            if (fetch_done_s) begin
               pc_nxt_s    = pend_nxt_s;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = PEND;
            end
         end
         HALT:    state_nxt_s = HALT;
         default: state_nxt_s = RUN;
      endcase
   end

   // Architectural registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= RUN;
         pc_r       <= align_pc(RESET_PC);
         pend_pc_r  <= 32'd0;
         pc_valid_r <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         pend_pc_r  <= pend_nxt_s;
         pc_valid_r <= (state_nxt_s != HALT);
         halted_r   <= (state_nxt_s == HALT);
      end
   end

   assign pc           = pc_r;
   assign pc_valid     = pc_valid_r;
   assign halted       = halted_r;
   assign if_id_flush  = flush_s  & ~rst;
   assign id_ex_bubble = bubble_s & ~rst;
   assign if_id_hold   = hold_s   & ~rst;

`ifdef PCFLOW_PERF_EN
   logic [31:0] stall_r, flush_cnt_r, redir_r;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r     <= 32'd0;
         flush_cnt_r <= 32'd0;
         redir_r     <= 32'd0;
      end else begin
         if (hold_s && stall_r != 32'hFFFF_FFFF) stall_r <= stall_r + 32'd1;
         if (flush_s && flush_cnt_r != 32'hFFFF_FFFF) flush_cnt_r <= flush_cnt_r + 32'd1;
         if (cause_s != NONE && redir_r != 32'hFFFF_FFFF) redir_r <= redir_r + 32'd1;
      end
   end

   assign perf_stall_cyc    = stall_r;
   assign perf_flush_cnt    = flush_cnt_r;
   assign perf_redirect_cnt = redir_r;
`endif

endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Sequencer for the fetch-PC datapath: owns the architectural PC register and decides each cycle between hold, sequential, jump-redirect and branch-redirect.
- Generates the pipeline-control strobes that go with each decision: IF/ID flush, ID/EX bubble and front-end hold.
- Tolerates a non-cancellable in-flight instruction fetch (imem_ready low) by parking a redirect until the fetch completes.
- Sits between the IF stage (instruction memory port) and the ID/EX hazard, jump and branch sources.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- imem_ready  in  1  fetch at current pc completes this cycle.
- load_use  in  1  ID load-use hazard: one-cycle bubble.
- mdu_busy  in  1  multi-cycle EX unit busy: freeze PC, IF/ID and ID/EX.
- j_en  in  1  ID-stage jump valid.
- j_pc  in  32  jump target.
- b_en  in  1  EX-stage branch taken.
- b_pc  in  32  branch target.
- halt_req  in  1  ID-stage halt (break) instruction.
- pc  out  32  fetch address (registered).
- pc_valid  out  1  fetch request valid (registered).
- if_id_flush  out  1  discard IF/ID contents at next edge (combinational).
- id_ex_bubble  out  1  insert NOP into ID/EX at next edge (combinational).
- if_id_hold  out  1  IF/ID keeps its value (combinational).
- halted  out  1  core halted (registered).

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst. On reset: pc=RESET_PC, pc_valid=0, halted=0, state=RUN, pend_pc=0. Combinational outputs are 0 while rst=1. First cycle after reset: pc_valid=1.
- States: RUN, PEND, HALT.
- Event priority in RUN, evaluated each cycle:
  - 1. mdu_busy=1: pc held; if_id_hold=1; no flush or bubble. b_en and j_en are ignored; EX never asserts b_en while busy, and the bench asserts this.
  - 2. b_en=1: target b_pc; if_id_flush=1; id_ex_bubble=1. Branch beats load_use, halt_req and j_en because the branch is older.
  - 3. load_use=1: pc held; if_id_hold=1; id_ex_bubble=1. Beats j_en because a jr may depend on the load.
  - 4. halt_req=1: next state HALT; if_id_flush=1; pc held.
  - 5. j_en=1: target j_pc; if_id_flush=1.
  - 6. Otherwise: if imem_ready, pc <= pc+PC_STEP (mod 2^32, wraps silently); else pc held.
- Redirect with imem_ready=1: pc <= target at the next edge (one-cycle latency).
- Redirect with imem_ready=0: pend_pc <= target, state <= PEND, pc held.
- PEND:
  - pc_valid stays 1 for the in-flight fetch.
  - When imem_ready=1: pc <= pend_pc, if_id_flush=1 (drops the wrong-path word), state <= RUN.
  - A new b_en while in PEND overwrites pend_pc.
  - j_en and halt_req are ignored in PEND: their ID instruction is wrong-path.
  - mdu_busy in PEND: pend_pc held; the transition is still taken on imem_ready.
- HALT: pc frozen, pc_valid=0, halted=1. Exit only via rst.
- Reset mid-PEND or mid-HALT: unconditional return to the reset values.
- Alignment: pc[1:0] is forced to 0 on every load.

Optional Feature:
- Macro: PCFLOW_PERF_EN.
- When defined, add three outputs, each a 32-bit saturating counter cleared by rst:
  - perf_stall_cyc: cycles with if_id_hold=1.
  - perf_flush_cnt: cycles with if_id_flush=1.
  - perf_redirect_cnt: accepted b_en/j_en redirects.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encoding (RUN=2'd0, PEND=2'd1, HALT=2'd2), RESET_PC default, PC_STEP, redirect-cause enum (NONE, BRANCH, JUMP).
- One natural sub-module, pc_redirect_prio: pure combinational priority resolver producing cause, target and the strobes.
- Top level keeps only the registers and the FSM.

Test Plan:
- Reset, then imem_ready=1 for 3 cycles -> pc sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; pc_valid=1 from the first post-reset cycle.
- b_en=1, b_pc=0x00400100 with j_en=1, j_pc=0x00400200 and load_use=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1; next pc=0x00400100.
- load_use=1 with j_en=1 -> if_id_hold=1, id_ex_bubble=1, pc unchanged. Next cycle j_en=1 alone -> pc=j_pc, if_id_flush=1.
- imem_ready=0, j_en=1, j_pc=0x00400040; imem_ready stays low 2 cycles, then high -> state PEND, pc held; pc=0x00400040 and if_id_flush=1 on the ready cycle.
- mdu_busy=1 for 5 cycles -> pc and IF/ID frozen, no bubble; with PCFLOW_PERF_EN defined, perf_stall_cyc increments by 5.
- halt_req=1 -> next cycle halted=1, pc_valid=0, pc frozen. rst=1 for one cycle -> pc=0x00400000, halted=0.
